// File: rtl/dot_product_host_sequencer.sv
// dot_product_host_sequencer
// Host-side initiator for the dot-product subsystem. It takes operand pairs
// from a valid/ready stream and writes them into the input memories. It then
// pulses start_reading and waits for both the reader and the writer to report
// done. Finally it reads the result bytes back and emits them LSB first on a
// valid/ready byte stream.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b    operand pair stream (input)
//   write_en/write_addr/data_a/b   input-memory write port
//   start_reading                  one-cycle job start pulse
//   reading_done/writer_done       phase completion (pulse or level)
//   read_en/read_addr/result_out   output-memory read port (1-cycle latency)
//   out_valid/out_ready/out_data   result byte stream, out_last on final byte
//   busy                           high whenever not IDLE
//   error                          sticky timeout flag, cleared only by rst
module dot_product_host_sequencer #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned VECTOR_WIDTH    = 4,
    parameter int unsigned ADDR_WIDTH      = 5,
    parameter int unsigned MEM3_ADDR_WIDTH = 4,
    parameter int unsigned RESULT_BYTES    = 3,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_a,
    input  logic [DATA_WIDTH-1:0]      in_b,
    output logic                       write_en,
    output logic [ADDR_WIDTH-1:0]      write_addr,
    output logic [DATA_WIDTH-1:0]      data_a,
    output logic [DATA_WIDTH-1:0]      data_b,
    output logic                       start_reading,
    input  logic                       reading_done,
    input  logic                       writer_done,
    output logic                       read_en,
    output logic [MEM3_ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0]      result_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_last,
    output logic                       busy,
    output logic                       error
);

    localparam int unsigned PAIR_W = $clog2(VECTOR_WIDTH + 1);
    localparam int unsigned BYTE_W = $clog2(RESULT_BYTES + 1);
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

    // CAPTURE is the cycle result_out is valid after a read_en; EMIT holds
    // the registered byte until the downstream handshake.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_DONE,
        S_READ,
        S_CAPTURE,
        S_EMIT,
        S_ERROR
    } state_t;

    state_t state_q, state_d;

    logic [PAIR_W-1:0] pair_cnt_q, pair_cnt_d;
    logic [BYTE_W-1:0] byte_idx_q, byte_idx_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              rd_seen_q, rd_seen_d;
    logic              wr_seen_q, wr_seen_d;

    logic                       in_ready_d;
    logic                       write_en_d;
    logic [ADDR_WIDTH-1:0]      write_addr_d;
    logic [DATA_WIDTH-1:0]      data_a_d;
    logic [DATA_WIDTH-1:0]      data_b_d;
    logic                       start_reading_d;
    logic                       read_en_d;
    logic [MEM3_ADDR_WIDTH-1:0] read_addr_d;
    logic                       out_valid_d;
    logic [DATA_WIDTH-1:0]      out_data_d;
    logic                       out_last_d;
    logic                       busy_d;
    logic                       error_d;

    logic accept_c;
    logic rd_now_c;
    logic wr_now_c;
    logic last_byte_c;

    assign accept_c    = in_valid & in_ready;
    assign rd_now_c    = rd_seen_q | reading_done;
    assign wr_now_c    = wr_seen_q | writer_done;
    assign last_byte_c = (byte_idx_q == BYTE_W'(RESULT_BYTES - 1));

    // State, counters and all output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pair_cnt_q    <= '0;
            byte_idx_q    <= '0;
            timer_q       <= '0;
            rd_seen_q     <= 1'b0;
            wr_seen_q     <= 1'b0;
            in_ready      <= 1'b1;
            write_en      <= 1'b0;
            write_addr    <= '0;
            data_a        <= '0;
            data_b        <= '0;
            start_reading <= 1'b0;
            read_en       <= 1'b0;
            read_addr     <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pair_cnt_q    <= pair_cnt_d;
            byte_idx_q    <= byte_idx_d;
            timer_q       <= timer_d;
            rd_seen_q     <= rd_seen_d;
            wr_seen_q     <= wr_seen_d;
            in_ready      <= in_ready_d;
            write_en      <= write_en_d;
            write_addr    <= write_addr_d;
            data_a        <= data_a_d;
            data_b        <= data_b_d;
            start_reading <= start_reading_d;
            read_en       <= read_en_d;
            read_addr     <= read_addr_d;
            out_valid     <= out_valid_d;
            out_data      <= out_data_d;
            out_last      <= out_last_d;
            busy          <= busy_d;
            error         <= error_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d         = state_q;
        pair_cnt_d      = pair_cnt_q;
        byte_idx_d      = byte_idx_q;
        timer_d         = timer_q;
        rd_seen_d       = rd_seen_q;
        wr_seen_d       = wr_seen_q;
        in_ready_d      = in_ready;
        write_en_d      = 1'b0;
        write_addr_d    = write_addr;
        data_a_d        = data_a;
        data_b_d        = data_b;
        start_reading_d = 1'b0;
        read_en_d       = 1'b0;
        read_addr_d     = read_addr;
        out_valid_d     = out_valid;
        out_data_d      = out_data;
        out_last_d      = out_last;
        error_d         = error;

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (pair_cnt_q == PAIR_W'(VECTOR_WIDTH)) begin
                    // Last write is on the bus this cycle; start follows it
                    pair_cnt_d      = '0;
                    start_reading_d = 1'b1;
                    state_d         = S_START;
                end else if (accept_c) begin
                    write_en_d   = 1'b1;
                    write_addr_d = ADDR_WIDTH'(pair_cnt_q);
                    data_a_d     = in_a;
                    data_b_d     = in_b;
                    pair_cnt_d   = pair_cnt_q + PAIR_W'(1);
                    state_d      = S_LOAD;
                    if (pair_cnt_q == PAIR_W'(VECTOR_WIDTH - 1)) begin
                        in_ready_d = 1'b0;
                    end
                end
            end

            S_START: begin
                rd_seen_d = 1'b0;
                wr_seen_d = 1'b0;
                timer_d   = '0;
                state_d   = S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
                rd_seen_d = rd_now_c;
                wr_seen_d = wr_now_c;
                if (rd_now_c && wr_now_c) begin
                    byte_idx_d  = '0;
                    read_en_d   = 1'b1;
                    read_addr_d = '0;
                    state_d     = S_READ;
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            S_READ: begin
                state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                out_valid_d = 1'b1;
                out_data_d  = result_out;
                out_last_d  = last_byte_c;
                state_d     = S_EMIT;
            end

            S_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (last_byte_c) begin
                        byte_idx_d = '0;
                        in_ready_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        byte_idx_d  = byte_idx_q + BYTE_W'(1);
                        read_en_d   = 1'b1;
                        read_addr_d = MEM3_ADDR_WIDTH'(byte_idx_q + BYTE_W'(1));
                        state_d     = S_READ;
                    end
                end
            end

            S_ERROR: begin
                state_d = S_ERROR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule
